hbm_rd_arbiter: RTL
===================

Name: hbm_rd_arbiter

Overview:
- Round-robin arbiter that shares one AXI4-MM read master (AR + R channels) of an HBM pseudo-channel between NUM_REQ CGRA column load units.
- Sits inside the data path, between the column load units and the m0x_axi read ports of the kernel top.
- One burst in flight at a time. R beats are routed back to the requester that owns the grant, and beat count is checked against arlen.

Parameters:
- NUM_REQ, 2, number of requesting columns (≥2).
- ADDR_W, 64, AXI address width.
- DATA_W, 512, AXI data width (phit size).
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- clk  in  1  kernel clock
- rst  in  1  synchronous active-high reset
- req_araddr  in  NUM_REQ*ADDR_W  per-requester burst address; requester i occupies slice i
- req_arlen  in  NUM_REQ*8  per-requester burst length minus 1
- req_arvalid  in  NUM_REQ  per-requester AR valid
- req_arready  out  NUM_REQ  per-requester AR accept (one-hot or zero)
- req_rdata  out  DATA_W  read data, broadcast to all requesters
- req_rvalid  out  NUM_REQ  read valid, asserted only to the granted requester
- req_rlast  out  NUM_REQ  last beat, asserted only to the granted requester
- req_rready  in  NUM_REQ  per-requester R ready
- m_axi_araddr  out  ADDR_W  to HBM
- m_axi_arlen  out  8  to HBM
- m_axi_arvalid  out  1  to HBM
- m_axi_arready  in  1  from HBM
- m_axi_rdata  in  DATA_W  from HBM
- m_axi_rvalid  in  1  from HBM
- m_axi_rlast  in  1  from HBM
- m_axi_rready  out  1  to HBM
- busy  out  1  high whenever the FSM is not in IDLE
- grant_id  out  $clog2(NUM_REQ)  index of the current or last granted requester
- len_err  out  1  sticky flag: rlast was inconsistent with arlen

Behaviour:

Reset:
- State IDLE, rr_ptr=0, grant_id=0, len_err=0.
- m_axi_arvalid=0, m_axi_araddr=0, m_axi_arlen=0.
- req_arready=0, req_rvalid=0, req_rlast=0, m_axi_rready=0, busy=0.
- Reset mid-burst aborts immediately to IDLE. No draining is done; the HBM side is reset by the same system reset.

FSM states: IDLE, ADDR, DATA.

IDLE:
- grant g = first i with req_arvalid[i]=1, searching from rr_ptr upward and wrapping mod NUM_REQ.
- req_arready[g]=1 combinationally in the same cycle. This is the only combinational valid-to-ready path.
- On that cycle, register araddr/arlen of g into m_axi_araddr/m_axi_arlen, set grant_id=g, load beat_cnt=arlen, and go to ADDR.
- No request pending: remain in IDLE.

ADDR:
- m_axi_arvalid=1. Address and length are held stable.
- On m_axi_arready=1: drop arvalid at the next edge and go to DATA.
- Latency: requester handshake at cycle t, m_axi_arvalid high at t+1.

DATA:
- m_axi_rready = req_rready[grant_id].
- req_rvalid[grant_id] = m_axi_rvalid; req_rlast[grant_id] = m_axi_rlast; all other bits 0.
- req_rdata = m_axi_rdata (pass-through, zero latency).
- Each accepted beat (rvalid & rready) decrements beat_cnt.
- On the accepted beat with rlast=1: set rr_ptr=(grant_id+1) mod NUM_REQ and go to IDLE.

len_err:
- Set when an accepted beat carries rlast=1 with beat_cnt≠0, or rlast=0 with beat_cnt=0.
- Sticky until rst.
- The burst still terminates only on rlast.

Boundary conditions:
- arlen=0 is a single-beat burst, with the rlast check applied.
- Simultaneous requests are served in round-robin order.
- A requester that keeps arvalid asserted cannot starve others, because rr_ptr advances past the granted index.
- rr_ptr wraps from NUM_REQ-1 to 0.
- At least one IDLE cycle separates consecutive bursts, so max AR rate is one per burst plus 2 cycles.
- A requester dropping arvalid while in IDLE without a handshake is allowed.

Optional Feature:
- Macro: HBM_RD_ARB_PERF_CNT_EN.
- Defined: adds output ports perf_bursts (NUM_REQ*CNT_W, per-requester count of completed bursts) and perf_stall (CNT_W, cycles in DATA with m_axi_rvalid=1 and m_axi_rready=0).
  - Both counters are cleared by rst and saturate at all-ones.
- Not defined: the ports are still present but tied to 0, and no counter logic is generated.

Test Plan:
- Single request: req0 araddr=0x1000, arlen=3 → m_axi_araddr=0x1000 and arlen=3 one cycle after req_arready[0]; 4 beats on req_rvalid[0] only; busy falls after rlast; len_err=0.
- Simultaneous: req0 and req1 both valid from reset → grant order 0,1,0,1 over 4 bursts; grant_id follows that order.
- Backpressure: req_rready[1]=0 for 5 cycles mid-burst → m_axi_rready=0 for those cycles; data is not lost; beat order is preserved.
- Length error: arlen=1 and slave asserts rlast on beat 0 → len_err=1 and stays high; FSM returns to IDLE.
- Reset mid-DATA: assert rst during beat 2 of 8 → next cycle all outputs are at reset values and rr_ptr=0.
- With HBM_RD_ARB_PERF_CNT_EN: 3 bursts on req0, 2 on req1, with 4 stall cycles → perf_bursts = {2,3}, perf_stall = 4.

Source files
------------

// File: rtl/hbm_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read master (AR + R) among NUM_REQ column load units.
// Optional macro HBM_RD_ARB_PERF_CNT_EN adds per-requester burst and stall counters.
module hbm_rd_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned DATA_W  = 512,
    parameter int unsigned CNT_W   = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NUM_REQ*ADDR_W-1:0]    req_araddr_i,
    input  logic [NUM_REQ*8-1:0]         req_arlen_i,
    input  logic [NUM_REQ-1:0]           req_arvalid_i,
    output logic [NUM_REQ-1:0]           req_arready_o,
    output logic [DATA_W-1:0]            req_rdata_o,
    output logic [NUM_REQ-1:0]           req_rvalid_o,
    output logic [NUM_REQ-1:0]           req_rlast_o,
    input  logic [NUM_REQ-1:0]           req_rready_i,
    output logic [ADDR_W-1:0]            m_axi_araddr_o,
    output logic [7:0]                   m_axi_arlen_o,
    output logic                         m_axi_arvalid_o,
    input  logic                         m_axi_arready_i,
    input  logic [DATA_W-1:0]            m_axi_rdata_i,
    input  logic                         m_axi_rvalid_i,
    input  logic                         m_axi_rlast_i,
    output logic                         m_axi_rready_o,
    output logic                         busy_o,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id_o,
    output logic                         len_err_o,
    output logic [NUM_REQ*CNT_W-1:0]     perf_bursts_o,
    output logic [CNT_W-1:0]             perf_stall_o
);

    localparam int unsigned IdW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

    state_e            state_q, state_d;
    logic [IdW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IdW-1:0]    grant_id_q, grant_id_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [7:0]        arlen_q, arlen_d;
    logic [7:0]        beat_cnt_q, beat_cnt_d;
    logic              len_err_q, len_err_d;

    logic              gnt_found;
    logic [IdW-1:0]    gnt_idx;
    int unsigned       cand;
    logic [ADDR_W-1:0] sel_addr;
    logic [7:0]        sel_len;
    logic              ar_hs;
    logic              beat_acc;

    // First pending requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = 32'(rr_ptr_q) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!gnt_found && req_arvalid_i[IdW'(cand)]) begin
                gnt_found = 1'b1;
                gnt_idx   = IdW'(cand);
            end
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_len  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == IdW'(i)) begin
                sel_addr = req_araddr_i[i*ADDR_W +: ADDR_W];
                sel_len  = req_arlen_i[i*8 +: 8];
            end
        end
    end

    assign ar_hs    = (state_q == StIdle) && gnt_found;
    assign beat_acc = (state_q == StData) && m_axi_rvalid_i && m_axi_rready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (ar_hs) state_d = StAddr;
            StAddr:  if (m_axi_arready_i) state_d = StData;
            StData:  if (beat_acc && m_axi_rlast_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // arready is masked during reset so no handshake is reported that the FSM will ignore.
    always_comb begin
        req_arready_o   = '0;
        req_rvalid_o    = '0;
        req_rlast_o     = '0;
        m_axi_rready_o  = 1'b0;
        m_axi_arvalid_o = 1'b0;
        case (state_q)
            StIdle: if (gnt_found && !rst_i) req_arready_o[gnt_idx] = 1'b1;
            StAddr: m_axi_arvalid_o = 1'b1;
            StData: begin
                m_axi_rready_o           = req_rready_i[grant_id_q];
                req_rvalid_o[grant_id_q] = m_axi_rvalid_i;
                req_rlast_o[grant_id_q]  = m_axi_rlast_i;
            end
            default: ;
        endcase
    end

    always_comb begin
        araddr_d   = araddr_q;
        arlen_d    = arlen_q;
        grant_id_d = grant_id_q;
        beat_cnt_d = beat_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        len_err_d  = len_err_q;
        if (ar_hs) begin
            araddr_d   = sel_addr;
            arlen_d    = sel_len;
            grant_id_d = gnt_idx;
            beat_cnt_d = sel_len;
        end
        if (beat_acc) begin
            if (beat_cnt_q != 8'd0) beat_cnt_d = beat_cnt_q - 8'd1;
            // rlast must coincide exactly with the final counted beat.
            if (m_axi_rlast_i != (beat_cnt_q == 8'd0)) len_err_d = 1'b1;
            if (m_axi_rlast_i) begin
                rr_ptr_d = (grant_id_q == IdW'(NUM_REQ - 1)) ? '0 : grant_id_q + IdW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            araddr_q   <= '0;
            arlen_q    <= '0;
            grant_id_q <= '0;
            beat_cnt_q <= '0;
            rr_ptr_q   <= '0;
            len_err_q  <= 1'b0;
        end else begin
            araddr_q   <= araddr_d;
            arlen_q    <= arlen_d;
            grant_id_q <= grant_id_d;
            beat_cnt_q <= beat_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            len_err_q  <= len_err_d;
        end
    end

    assign req_rdata_o    = m_axi_rdata_i;
    assign m_axi_araddr_o = araddr_q;
    assign m_axi_arlen_o  = arlen_q;
    assign busy_o         = (state_q != StIdle);
    assign grant_id_o     = grant_id_q;
    assign len_err_o      = len_err_q;

`ifdef HBM_RD_ARB_PERF_CNT_EN
    logic [CNT_W-1:0] bursts_q [NUM_REQ];
    logic [CNT_W-1:0] bursts_d [NUM_REQ];
    logic [CNT_W-1:0] stall_q, stall_d;

    // Both counters saturate at all-ones rather than wrapping.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) bursts_d[i] = bursts_q[i];
        stall_d = stall_q;
        if (beat_acc && m_axi_rlast_i && bursts_q[grant_id_q] != '1) begin
            bursts_d[grant_id_q] = bursts_q[grant_id_q] + CNT_W'(1);
        end
        if ((state_q == StData) && m_axi_rvalid_i && !m_axi_rready_o && stall_q != '1) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) bursts_q[i] <= '0;
            stall_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) bursts_q[i] <= bursts_d[i];
            stall_q <= stall_d;
        end
    end

    always_comb begin
        perf_bursts_o = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) perf_bursts_o[i*CNT_W +: CNT_W] = bursts_q[i];
    end
    assign perf_stall_o = stall_q;
`else
    assign perf_bursts_o = '0;
    assign perf_stall_o  = '0;
`endif

endmodule
